// File: rtl/multi_hash_validator.sv
// Checks NUM_CH 256-bit hashes per beat against a compact-difficulty target.
// The 256-bit compare is split MSB-first across CMP_STAGES stages, after one input register.
module multi_hash_validator #(
  parameter  int NUM_CH     = 4,
  parameter  int CMP_STAGES = 4,
  parameter  int NONCE_W    = 32,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    diff_load,
  input  logic [31:0]             difficulty,
  output logic                    diff_busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*256-1:0]   in_hash,
  input  logic [NONCE_W-1:0]      in_nonce,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_hit,
  output logic [CH_W-1:0]         out_channel,
  output logic [NONCE_W-1:0]      out_nonce,
  output logic [31:0]             hit_count
);
  localparam int SW = 256 / CMP_STAGES;

  typedef enum logic {IDLE, CALC} state_e;

  state_e              state_q, state_d;
  logic [31:0]         diff_q;
  logic [255:0]        target_q, target_calc;
  logic [31:0]         hit_count_q;
  logic                load_accept, beat_accept, stall, advance, pipe_busy;
  logic [CMP_STAGES:0] valid_vec;
  logic [NUM_CH-1:0]   lt_last;

  logic [255:0]        in_num [NUM_CH];
  logic [255:0]        in_num_q [NUM_CH];
  logic                in_v_q;
  logic [NONCE_W-1:0]  in_nonce_q;

  assign stall       = out_valid && !out_ready;
  assign advance     = !stall;
  assign in_ready    = (state_q == IDLE) && !stall;
  assign beat_accept = in_valid && in_ready;
  assign pipe_busy   = |valid_vec;
  assign diff_busy   = (state_q == CALC) || pipe_busy;

  // A load coinciding with a beat accept is refused so the beat sees one target end to end.
  always_comb begin
    state_d     = state_q;
    load_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (diff_load && !pipe_busy && !beat_accept) begin
          load_accept = 1'b1;
          state_d     = CALC;
        end
      end
      CALC: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic [255:0] mant;
    logic [7:0]   expo;
    mant = {232'd0, diff_q[15:8], diff_q[23:16], diff_q[31:24]};
    expo = diff_q[7:0];
    if (expo > 8'd32)
      target_calc = '1;
    else if (expo >= 8'd3)
      target_calc = mant << {expo - 8'd3, 3'b000};
    else
      target_calc = mant >> {8'd3 - expo, 3'b000};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      diff_q   <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_accept) diff_q <= difficulty;
      if (state_q == CALC) target_q <= target_calc;
    end
  end

  // Hash byte j becomes number byte 31-j.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < 32; b++)
        in_num[c][8*b +: 8] = in_hash[256*c + 8*(31-b) +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_v_q     <= 1'b0;
      in_nonce_q <= '0;
    end else if (advance) begin
      in_v_q     <= beat_accept;
      in_nonce_q <= in_nonce;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) in_num_q <= in_num;
  end

  assign valid_vec[0] = in_v_q;

  genvar gi, gc;
  generate
    for (gi = 0; gi < CMP_STAGES; gi++) begin : g_stage
      localparam int HI = 256 - gi*SW;
      logic [HI-1:0]        num_src [NUM_CH];
      logic [NUM_CH-1:0]    lt_src, eq_src, lt_d, lt_q;
      logic                 valid_src, valid_q;
      logic [NONCE_W-1:0]   nonce_src, nonce_q;

      if (gi == 0) begin : g_first
        assign valid_src = in_v_q;
        assign nonce_src = in_nonce_q;
        assign lt_src    = '0;
        assign eq_src    = '1;
        for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
          assign num_src[gc] = in_num_q[gc];
        end
      end else begin : g_next
        assign valid_src = g_stage[gi-1].valid_q;
        assign nonce_src = g_stage[gi-1].nonce_q;
        assign lt_src    = g_stage[gi-1].lt_q;
        assign eq_src    = g_stage[gi-1].g_carry.eq_q;
        for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
          assign num_src[gc] = g_stage[gi-1].g_carry.rem_q[gc];
        end
      end

      always_comb begin
        lt_d = '0;
        for (int c = 0; c < NUM_CH; c++)
          lt_d[c] = valid_src && (lt_src[c] ||
                    (eq_src[c] && (num_src[c][HI-1 -: SW] < target_q[HI-1 -: SW])));
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          nonce_q <= '0;
          lt_q    <= '0;
        end else if (advance) begin
          valid_q <= valid_src;
          nonce_q <= nonce_src;
          lt_q    <= lt_d;
        end
      end

      // Equality flags and the not-yet-compared low bits only travel while slices remain.
      if (gi < CMP_STAGES-1) begin : g_carry
        logic [NUM_CH-1:0] eq_d, eq_q;
        logic [HI-SW-1:0]  rem_q [NUM_CH];

        always_comb begin
          eq_d = '0;
          for (int c = 0; c < NUM_CH; c++)
            eq_d[c] = valid_src && eq_src[c] &&
                      (num_src[c][HI-1 -: SW] == target_q[HI-1 -: SW]);
        end

        always_ff @(posedge clk or negedge rst) begin
          if (!rst)         eq_q <= '0;
          else if (advance) eq_q <= eq_d;
        end

        always_ff @(posedge clk) begin
          if (advance)
            for (int c = 0; c < NUM_CH; c++)
              rem_q[c] <= num_src[c][HI-SW-1:0];
        end
      end

      assign valid_vec[gi+1] = valid_q;
    end
  endgenerate

  assign out_valid = g_stage[CMP_STAGES-1].valid_q;
  assign out_nonce = g_stage[CMP_STAGES-1].nonce_q;
  assign lt_last   = g_stage[CMP_STAGES-1].lt_q;
  assign out_hit   = |lt_last;

  always_comb begin
    out_channel = '0;
    for (int c = NUM_CH-1; c >= 0; c--)
      if (lt_last[c]) out_channel = CH_W'(c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hit_count_q <= '0;
    else if (out_valid && out_ready && out_hit && (hit_count_q != 32'hFFFF_FFFF))
      hit_count_q <= hit_count_q + 32'd1;
  end

  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_multi_hash_validator.sv
// Bench for multi_hash_validator: directed vector table, stall/stream and reset sequences,
// and randomized traffic checked cycle by cycle against a queue-based reference model.
module tb_multi_hash_validator;
  localparam int NUM_CH  = 4;
  localparam int STAGES  = 4;
  localparam int NONCE_W = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  diff_load = 1'b0;
  logic [31:0]           difficulty = '0;
  logic                  diff_busy;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [NUM_CH*256-1:0] in_hash = '0;
  logic [NONCE_W-1:0]    in_nonce = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic                  out_hit;
  logic [1:0]            out_channel;
  logic [NONCE_W-1:0]    out_nonce;
  logic [31:0]           hit_count;

  always #5 clk = ~clk;

  multi_hash_validator #(.NUM_CH(NUM_CH), .CMP_STAGES(STAGES), .NONCE_W(NONCE_W)) dut (
    .clk(clk), .rst(rst), .diff_load(diff_load), .difficulty(difficulty),
    .diff_busy(diff_busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_hash(in_hash), .in_nonce(in_nonce), .out_valid(out_valid),
    .out_ready(out_ready), .out_hit(out_hit), .out_channel(out_channel),
    .out_nonce(out_nonce), .hit_count(hit_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic hit; int ch; logic [31:0] nonce; int age; } beat_t;
  beat_t        mq[$];
  logic [255:0] m_target, m_pending;
  bit           m_calc;
  logic [31:0]  m_hits;
  bit           m_accept;

  logic [NUM_CH-1:0][255:0] cur_num;
  logic         act_hit;
  int           act_ch;
  logic [31:0]  act_nonce;
  int           act_del = 0;
  bit           saw_rdy_low;

  typedef struct { logic [31:0] diff; logic [NUM_CH-1:0][255:0] num; logic hit; int ch; } vec_t;
  vec_t tbl [8];

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] ref_target(logic [31:0] d);
    logic [255:0] m;
    int e;
    m = {232'd0, d[15:8], d[23:16], d[31:24]};
    e = int'(d[7:0]);
    if (e > 32) return '1;
    if (e >= 3) return m << (8 * (e - 3));
    return m >> (8 * (3 - e));
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_beat(logic [NUM_CH-1:0][255:0] n, logic [31:0] nonce);
    cur_num  = n;
    in_nonce = nonce;
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < 32; b++)
        in_hash[256*c + 8*b +: 8] = n[c][8*(31-b) +: 8];
  endtask

  task automatic model_reset();
    mq.delete();
    m_target = '0;
    m_pending = '0;
    m_calc = 1'b0;
    m_hits = '0;
  endtask

  // One clock: called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    logic  exp_ov, exp_rdy, exp_busy, deliver, adv, load_acc;
    beat_t nb;
    #1;
    exp_ov   = (mq.size() > 0) && (mq[0].age >= STAGES);
    exp_rdy  = !m_calc && !(exp_ov && !out_ready);
    exp_busy = m_calc || (mq.size() > 0);
    check("out_valid", out_valid, exp_ov);
    check("in_ready", in_ready, exp_rdy);
    check("diff_busy", diff_busy, exp_busy);
    check("hit_count", hit_count, m_hits);
    if (exp_ov) begin
      check("out_hit", out_hit, mq[0].hit);
      check("out_channel", 256'(out_channel), 256'(mq[0].ch));
      check("out_nonce", out_nonce, mq[0].nonce);
    end
    if (!in_ready) saw_rdy_low = 1'b1;
    if (out_valid && out_ready) begin
      act_hit = out_hit; act_ch = int'(out_channel); act_nonce = out_nonce; act_del++;
    end
    deliver  = exp_ov && out_ready;
    adv      = !(exp_ov && !out_ready);
    m_accept = in_valid && exp_rdy;
    load_acc = diff_load && !exp_busy && !m_accept;
    nb.hit = 1'b0; nb.ch = 0; nb.nonce = in_nonce; nb.age = 0;
    for (int c = NUM_CH-1; c >= 0; c--)
      if (cur_num[c] < m_target) begin nb.hit = 1'b1; nb.ch = c; end
    @(posedge clk);
    if (deliver) begin
      if (mq[0].hit && m_hits != 32'hFFFF_FFFF) m_hits++;
      void'(mq.pop_front());
    end
    if (adv) foreach (mq[i]) mq[i].age++;
    if (m_accept) mq.push_back(nb);
    if (m_calc) m_target = m_pending;
    m_calc = load_acc;
    if (load_acc) m_pending = ref_target(difficulty);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; diff_load = 1'b0; out_ready = 1'b1;
    while ((mq.size() > 0 || m_calc) && n < 100) begin step(); n++; end
    if (mq.size() > 0 || m_calc) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", mq.size());
    end
  endtask

  task automatic load(logic [31:0] d);
    difficulty = d; diff_load = 1'b1;
    step();
    diff_load = 1'b0;
    drain();
  endtask

  task automatic send(logic [NUM_CH-1:0][255:0] n, logic [31:0] nonce);
    set_beat(n, nonce);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] ones, t1;
    logic [NUM_CH-1:0][255:0] n;
    logic [31:0] cur_diff;
    logic [31:0] dlist [4];
    int lat, sent, del0;

    ones = '1;
    t1 = 256'hFFFF;
    t1 = t1 << 208;
    dlist[0] = 32'hFFFF001D; dlist[1] = 32'h56341202;
    dlist[2] = 32'h00000021; dlist[3] = 32'h3412AB20;

    tbl[0].diff = 32'hFFFF001D; tbl[0].num = {ones, t1 - 256'd1, ones, ones};   tbl[0].hit = 1; tbl[0].ch = 2;
    tbl[1].diff = 32'hFFFF001D; tbl[1].num = {t1, t1, t1, t1};                  tbl[1].hit = 0; tbl[1].ch = 0;
    tbl[2].diff = 32'hFFFF001D; tbl[2].num = {256'd0, ones, t1 - 256'd1, ones}; tbl[2].hit = 1; tbl[2].ch = 1;
    tbl[3].diff = 32'h56341202; tbl[3].num = {ones, ones, ones, 256'h1233};     tbl[3].hit = 1; tbl[3].ch = 0;
    tbl[4].diff = 32'h56341202; tbl[4].num = {256'h1234, ones, ones, ones};     tbl[4].hit = 0; tbl[4].ch = 0;
    tbl[5].diff = 32'h56341202; tbl[5].num = {256'h1233, ones, ones, 256'h1234}; tbl[5].hit = 1; tbl[5].ch = 3;
    tbl[6].diff = 32'h00000021; tbl[6].num = {ones, ones, ones - 256'd1, ones}; tbl[6].hit = 1; tbl[6].ch = 1;
    tbl[7].diff = 32'h00000021; tbl[7].num = {ones, ones, ones, ones};          tbl[7].hit = 0; tbl[7].ch = 0;

    model_reset();
    set_beat('0, '0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff_busy", diff_busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_hit_count", hit_count, 0);
    check("rst_out_hit", out_hit, 0);
    check("rst_out_channel", 256'(out_channel), 0);
    check("rst_out_nonce", out_nonce, 0);
    rst = 1'b1;

    // First beat after reset: zero target, fixed latency, miss.
    n = {rand256(), rand256(), rand256(), rand256()};
    send(n, 32'hA0);
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    check("first_latency", lat, STAGES);
    check("first_hit", out_hit, 0);
    drain();
    check("first_hit_count", hit_count, 0);

    cur_diff = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].diff != cur_diff) begin load(tbl[i].diff); cur_diff = tbl[i].diff; end
      send(tbl[i].num, 32'd100 + i);
      drain();
      check("tbl_hit", act_hit, tbl[i].hit);
      check("tbl_channel", act_ch, tbl[i].ch);
      check("tbl_nonce", act_nonce, 32'd100 + i);
    end

    // Stream of 20 beats with a 10-cycle output stall and ignored loads.
    load(32'hFFFF001D);
    sent = 0; del0 = act_del; saw_rdy_low = 1'b0;
    for (int cyc = 0; cyc < 80 && (sent < 20 || mq.size() > 0); cyc++) begin
      out_ready  = !(cyc >= 8 && cyc < 18);
      diff_load  = (cyc == 5 || cyc == 12);
      difficulty = 32'h00000021;
      in_valid   = (sent < 20);
      for (int c = 0; c < NUM_CH; c++) n[c] = ($urandom % 2) ? (t1 - 256'd1) : rand256();
      set_beat(n, 32'd1000 + sent);
      step();
      if (m_accept) sent++;
    end
    drain();
    check("stream_delivered", act_del - del0, 20);
    check("stream_last_nonce", act_nonce, 32'd1019);
    check("stream_stall_ready", saw_rdy_low, 1);
    send({t1, t1, t1, t1}, 32'hBEEF);
    drain();
    check("target_kept", act_hit, 0);

    // Randomized traffic with occasional loads.
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 4) != 0;
      diff_load  = ($urandom % 12) == 0;
      difficulty = dlist[$urandom % 4];
      for (int c = 0; c < NUM_CH; c++) begin
        case ($urandom % 6)
          0: n[c] = m_target - 256'd1;
          1: n[c] = m_target;
          2: n[c] = m_target + 256'd1;
          3: n[c] = rand256();
          4: n[c] = ones;
          default: n[c] = '0;
        endcase
      end
      set_beat(n, $urandom);
      step();
    end
    drain();

    // Reset with beats in flight.
    rst = 1'b0; model_reset();
    @(negedge clk); rst = 1'b1;
    load(32'h00000021);
    for (int i = 0; i < 5; i++) begin
      send({rand256(), rand256(), rand256(), rand256()}, 32'd200 + i);
    end
    drain();
    check("pre_rst_hits", hit_count, 5);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat({rand256(), rand256(), rand256(), rand256()}, 32'd300 + i);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_hit_count", hit_count, 0);
    check("mid_rst_diff_busy", diff_busy, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    del0 = act_del;
    repeat (10) step();
    check("no_stale_output", act_del - del0, 0);
    send({256'd0, 256'd0, 256'd0, 256'd0}, 32'h55);
    drain();
    check("post_rst_zero_target", act_hit, 0);
    check("post_rst_nonce", act_nonce, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
